// File: rtl/stream_edge_filter.sv
// Streaming 3x3 Sobel/Prewitt edge filter over a raster pixel stream.
// Two line buffers plus a small window; one output per accepted input after a W+1 fill.
module stream_edge_filter #(
    parameter int IMG_WIDTH  = 45,
    parameter int IMG_HEIGHT = 45,
    parameter int PIX_W      = 8,
    parameter int SHIFT      = 3,
    parameter int THRESH     = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W-1:0] m_data,
    output logic             m_sof,
    output logic             m_last,
    output logic             busy
);

    localparam int N  = IMG_WIDTH * IMG_HEIGHT;
    localparam int CW = $clog2(N + 1);
    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam int MW = PIX_W + 4;
    localparam logic [MW-1:0] MAXV = MW'((1 << PIX_W) - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     in_cnt_q, out_cnt_q;
    logic [XW-1:0]     col_q;
    logic [YW-1:0]     row_q;
    logic              mode_q;
    logic [PIX_W-1:0]  lb0 [IMG_WIDTH];
    logic [PIX_W-1:0]  lb1 [IMG_WIDTH];
    logic [PIX_W-1:0]  win_q [3][2];
    logic [PIX_W-1:0]  col_in [3];
    logic              m_valid_q, m_sof_q, m_last_q;
    logic [PIX_W-1:0]  m_data_q;

    logic              acc, out_hs, out_free, last_in, emit, border, flush_load, load;
    logic [PIX_W-1:0]  pix_val;

    assign out_free   = !m_valid_q || m_ready;
    assign out_hs     = m_valid_q && m_ready;
    assign acc        = s_valid && s_ready;
    assign last_in    = (in_cnt_q == CW'(N - 1));
    assign emit       = acc && (in_cnt_q >= CW'(IMG_WIDTH + 1));
    // Centre sits one row up and one column left of the incoming pixel.
    assign border     = (row_q == YW'(1)) || (col_q <= XW'(1));
    assign flush_load = (state_q == FLUSH) && out_free && (out_cnt_q < CW'(N));
    assign load       = emit || flush_load;

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (acc) state_d = RUN;
            RUN:     if (acc && last_in) state_d = FLUSH;
            FLUSH:   if (out_hs && m_last_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        s_ready = rst && (state_q != FLUSH) && out_free;
        busy    = (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_cnt_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
            mode_q   <= 1'b0;
        end else if (acc) begin
            if (state_q == IDLE) mode_q <= mode;
            if (last_in) begin
                in_cnt_q <= '0;
                col_q    <= '0;
                row_q    <= '0;
            end else begin
                in_cnt_q <= in_cnt_q + 1'b1;
                if (col_q == XW'(IMG_WIDTH - 1)) begin
                    col_q <= '0;
                    row_q <= row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            lb1[col_q] <= lb0[col_q];
            lb0[col_q] <= s_data;
        end
    end

    // Window right column is the live line-buffer/input read; left and centre columns are registered.
    always_comb begin
        col_in[0] = lb1[col_q];
        col_in[1] = lb0[col_q];
        col_in[2] = s_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned r = 0; r < 3; r++) begin
                win_q[r][0] <= '0;
                win_q[r][1] <= '0;
            end
        end else if (acc) begin
            for (int unsigned r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= col_in[r];
            end
        end
    end

    function automatic logic signed [MW-1:0] ext(input logic [PIX_W-1:0] p);
        return $signed({4'b0000, p});
    endfunction

    logic signed [MW-1:0] gx, gy, dx, dy;
    logic        [MW-1:0] ax, ay, mag, v;
    logic        [PIX_W-1:0] sat;

    always_comb begin
        gx = (ext(col_in[0]) + ext(col_in[2])) - (ext(win_q[0][0]) + ext(win_q[2][0]));
        gy = (ext(win_q[2][0]) + ext(col_in[2])) - (ext(win_q[0][0]) + ext(col_in[0]));
        dx = ext(col_in[1]) - ext(win_q[1][0]);
        dy = ext(win_q[2][1]) - ext(win_q[0][1]);
        if (mode_q) begin
            gx = gx + dx;
            gy = gy + dy;
        end else begin
            gx = gx + (dx <<< 1);
            gy = gy + (dy <<< 1);
        end
        ax  = gx[MW-1] ? $unsigned(-gx) : $unsigned(gx);
        ay  = gy[MW-1] ? $unsigned(-gy) : $unsigned(gy);
        mag = ax + ay;
        v   = mag >> SHIFT;
        sat = (v > MAXV) ? '1 : v[PIX_W-1:0];
        if (border || ({4'b0000, sat} < MW'(THRESH))) pix_val = '0;
        else                                            pix_val = sat;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_sof_q   <= 1'b0;
            m_last_q  <= 1'b0;
            out_cnt_q <= '0;
        end else begin
            if (load) begin
                m_valid_q <= 1'b1;
                m_data_q  <= emit ? pix_val : '0;
                m_sof_q   <= (out_cnt_q == '0);
                m_last_q  <= (out_cnt_q == CW'(N - 1));
                out_cnt_q <= out_cnt_q + 1'b1;
            end else if (out_hs) begin
                m_valid_q <= 1'b0;
                if (m_last_q) out_cnt_q <= '0;
            end
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_sof   = m_sof_q;
    assign m_last  = m_last_q;

endmodule

// File: tb/tb_stream_edge_filter.sv
// Directed bench for stream_edge_filter on a 5x5 frame: flat, step, threshold,
// stall, mid-frame reset and back-to-back mode latching.
module tb_stream_edge_filter;

    localparam int W = 5;
    localparam int H = 5;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_sof;
    logic       m_last;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int got_d[$];
    int got_s[$];
    int got_l[$];

    stream_edge_filter #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .mode   (mode),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data (s_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data (m_data),
        .m_sof  (m_sof),
        .m_last (m_last),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // pat 0: flat 100; pat 1: columns 0-1 = 0, columns 2-4 = hgt
    function automatic int pixel(input int pat, input int hgt, input int idx);
        if (pat == 0) return 100;
        return ((idx % W) >= 2) ? hgt : 0;
    endfunction

    // Step response: interior rows 1-3, columns 1-2 carry val, everything else 0
    function automatic int expv(input int val, input int i);
        int r = i / W;
        int c = i % W;
        return (r >= 1 && r <= 3 && c >= 1 && c <= 2) ? val : 0;
    endfunction

    task automatic run_frame(input int pat, input int hgt, input bit mode_a, input bit mode_b,
                             input int toggle_at, input bit stall, input int abort_after);
        int  idx = 0;
        int  cyc = 0;
        bit  done = 0;
        bit  busy_seen = 0;
        bit  prev_stall = 0;
        int  pd = 0, ps = 0, pl = 0;
        got_d.delete();
        got_s.delete();
        got_l.delete();
        while (!done && cyc < 600) begin
            @(negedge clk);
            m_ready = stall ? (cyc % 3 == 0) : 1'b1;
            s_valid = (idx < N) && !(abort_after >= 0 && idx >= abort_after);
            s_data  = 8'(pixel(pat, hgt, idx));
            mode    = (idx >= toggle_at) ? mode_b : mode_a;
            #1;
            if (cyc == 0) check("busy_idle_at_start", busy, 0);
            if (prev_stall && m_valid) begin
                check("hold_data", m_data, pd);
                check("hold_flags", {m_sof, m_last}, {ps[0], pl[0]});
            end
            if (m_valid && !m_ready) check("stall_blocks_input", s_ready, 0);
            prev_stall = m_valid && !m_ready;
            pd = m_data; ps = m_sof; pl = m_last;
            if (m_valid && m_ready) begin
                got_d.push_back(m_data);
                got_s.push_back(m_sof);
                got_l.push_back(m_last);
                if (m_last) done = 1;
            end
            if (s_valid && s_ready) idx++;
            if (idx == 10 && !busy_seen) begin
                busy_seen = 1;
                check("busy_mid_frame", busy, 1);
            end
            cyc++;
            if (abort_after >= 0 && idx >= abort_after) done = 1;
        end
        if (abort_after < 0) check("frame_completed", done, 1);
    endtask

    task automatic check_outputs(input string tag, input int val);
        check({tag, "_count"}, got_d.size(), N);
        for (int i = 0; i < N; i++) begin
            if (i < got_d.size()) begin
                check({tag, "_data"}, got_d[i], expv(val, i));
                check({tag, "_sof"}, got_s[i], int'(i == 0));
                check({tag, "_last"}, got_l[i], int'(i == N - 1));
            end
        end
    endtask

    initial begin
        rst     = 1'b0;
        mode    = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_s_ready", s_ready, 0);
        check("reset_m_valid", m_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_flags", {m_sof, m_last}, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("s_ready_after_reset", s_ready, 1);

        // Flat frame: every output zero
        run_frame(0, 100, 1'b0, 1'b0, N, 1'b0, -1);
        check_outputs("flat", 0);

        run_frame(1, 80, 1'b0, 1'b0, N, 1'b0, -1);
        check_outputs("sobel80", 40);

        run_frame(1, 80, 1'b1, 1'b1, N, 1'b0, -1);
        check_outputs("prewitt80", 30);

        // gx = 64 -> v = 8 falls under the threshold
        run_frame(1, 16, 1'b0, 1'b0, N, 1'b0, -1);
        check_outputs("sobel16", 0);

        run_frame(1, 80, 1'b0, 1'b0, N, 1'b1, -1);
        check_outputs("stall", 40);

        // Abandon a frame after 12 accepts, then restart cleanly
        run_frame(1, 80, 1'b0, 1'b0, N, 1'b0, 12);
        @(negedge clk);
        s_valid = 1'b0;
        rst     = 1'b0;
        #1;
        check("midreset_m_valid", m_valid, 0);
        check("midreset_busy", busy, 0);
        check("midreset_s_ready", s_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        run_frame(1, 80, 1'b0, 1'b0, N, 1'b0, -1);
        check_outputs("after_reset", 40);

        // mode flips at pixel 7 of frame 1; frame 2 starts with mode = 1
        run_frame(1, 80, 1'b0, 1'b1, 7, 1'b0, -1);
        check_outputs("b2b_f1", 40);
        run_frame(1, 80, 1'b1, 1'b1, N, 1'b0, -1);
        check_outputs("b2b_f2", 30);

        @(negedge clk);
        #1;
        check("busy_end", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
